// File: rtl/mac_seq_ctrl_if.sv
// Request/response bus between CPU execute/writeback and the MUL/MAC sequencer.
// Handshake: a beat transfers on a rising clk edge where valid && ready are both high;
// valid holds its payload stable until that edge.
interface mac_seq_ctrl_if;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [15:0] op_rs;
  logic [15:0] op_rd;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;

  modport master (
    output op_valid, op_code, op_rs, op_rd, res_ready,
    input  op_ready, res_valid, res_data
  );

  modport slave (
    input  op_valid, op_code, op_rs, op_rd, res_ready,
    output op_ready, res_valid, res_data
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Execute-stage MUL/MAC sequencer around an external combinational 16-bit multiplier.
// Optional macro MAC_SAT_EN: unsigned saturation of the accumulator on MAC overflow.
module mac_seq_ctrl #(
  parameter int unsigned MUL_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mac_seq_ctrl_if.slave     bus,
  output logic [15:0]       mul_rs,
  output logic [15:0]       mul_rd,
  input  logic [15:0]       mul_q,
  output logic              acc_ovf,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MAC   = 2'b01;
  localparam logic [1:0] OP_CLR   = 2'b10;
  localparam logic [3:0] CNT_INIT = 4'(MUL_WAIT - 1);

  state_t      state;
  logic [1:0]  op_q;
  logic [3:0]  cnt;
  logic [15:0] acc;
  logic [16:0] mac_sum;

  assign mac_sum      = {1'b0, acc} + {1'b0, mul_q};
  assign bus.op_ready = (state == IDLE) && !rst;
  assign busy         = (state != IDLE);
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= OP_MUL;
      cnt           <= 4'd0;
      acc           <= 16'd0;
      acc_ovf       <= 1'b0;
      mul_rs        <= 16'd0;
      mul_rd        <= 16'd0;
      bus.res_data  <= 16'd0;
      bus.res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            op_q <= bus.op_code;
            case (bus.op_code)
              OP_MUL, OP_MAC: begin
                mul_rs <= bus.op_rs;
                mul_rd <= bus.op_rd;
                cnt    <= CNT_INIT;
                state  <= WAIT;
              end
              OP_CLR: begin
                acc           <= 16'd0;
                acc_ovf       <= 1'b0;
                bus.res_data  <= 16'd0;
                bus.res_valid <= 1'b1;
                state         <= RESP;
              end
              default: begin
                bus.res_data  <= acc;
                bus.res_valid <= 1'b1;
                state         <= RESP;
              end
            endcase
          end
        end
        WAIT: begin
          // Product is sampled only once the settle window has fully elapsed.
          if (cnt == 4'd0) begin
            if (op_q == OP_MAC) begin
              acc_ovf <= acc_ovf | mac_sum[16];
`ifdef MAC_SAT_EN
              if (mac_sum[16]) begin
                acc          <= 16'hFFFF;
                bus.res_data <= 16'hFFFF;
              end else begin
                acc          <= mac_sum[15:0];
                bus.res_data <= mac_sum[15:0];
              end
`else
              acc          <= mac_sum[15:0];
              bus.res_data <= mac_sum[15:0];
`endif
            end else begin
              bus.res_data <= mul_q;
            end
            bus.res_valid <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: expected {acc_ovf,res_data} pushed at issue, popped by a monitor.
module tb_mac_seq_ctrl;
  localparam int unsigned MUL_WAIT = 2;
  localparam int W = 17;

  logic        clk;
  logic        rst;
  logic [15:0] mul_rs, mul_rd, mul_q;
  logic        acc_ovf, busy;
  logic [1:0]  dbg_state;

  mac_seq_ctrl_if bus();

  mac_seq_ctrl #(.MUL_WAIT(MUL_WAIT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mul_rs(mul_rs), .mul_rd(mul_rd), .mul_q(mul_q),
    .acc_ovf(acc_ovf), .busy(busy), .dbg_state(dbg_state)
  );

  // Multiplier model: low 16 bits of the product.
  logic [31:0] full_prod;
  assign full_prod = mul_rs * mul_rd;
  assign mul_q     = full_prod[15:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Monitor: a transfer happens on the next rising edge whenever valid && ready here.
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      logic [W-1:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got ovf=%0b data=%h, none required", acc_ovf, bus.res_data);
      end else begin
        e = exp_q.pop_front();
        if ({acc_ovf, bus.res_data} !== e) begin
          n_err++;
          $display("FAIL result: got ovf=%0b data=%h, required ovf=%0b data=%h",
                   acc_ovf, bus.res_data, e[16], e[15:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Issue one request; returns one cycle after the accepting edge (cycle 1).
  task automatic issue(input logic [1:0] code, input logic [15:0] a, input logic [15:0] b,
                       input bit push, input logic [W-1:0] exp);
    int t = 0;
    while (!bus.op_ready && t < 50) begin
      tick();
      t++;
    end
    if (!bus.op_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL op_ready_timeout: got 0, required 1");
    end
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_rs    = a;
    bus.op_rd    = b;
    if (push) exp_q.push_back(exp);
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin
      tick();
      t++;
    end
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: got busy=1, required 0");
    end
  endtask

  task automatic run(input logic [1:0] code, input logic [15:0] a, input logic [15:0] b,
                     input logic [W-1:0] exp);
    issue(code, a, b, 1'b1, exp);
    wait_idle();
  endtask

  logic [15:0] sat_exp;

  initial begin
`ifdef MAC_SAT_EN
    sat_exp = 16'hFFFF;
`else
    sat_exp = 16'h1170;
`endif
    rst = 1'b1;
    bus.op_valid  = 1'b0;
    bus.op_code   = 2'b00;
    bus.op_rs     = 16'd0;
    bus.op_rd     = 16'd0;
    bus.res_ready = 1'b1;

    // Reset: two cycles, op_valid asserted to show reset wins.
    bus.op_valid = 1'b1;
    bus.op_code  = 2'b11;
    tick();
    check("rst_op_ready", 17'(bus.op_ready), 17'd0);
    check("rst_outputs", {acc_ovf, bus.res_data}, 17'd0);
    tick();
    check("rst_regs", {bus.res_valid, busy, mul_rs[0], mul_rd}, 17'd0);
    check("rst_mul_rs", 17'(mul_rs), 17'd0);
    bus.op_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_op_ready", 17'(bus.op_ready), 17'd1);

    // MUL 3*5 cycle-accurate timing.
    issue(2'b00, 16'd3, 16'd5, 1'b1, {1'b0, 16'd15});
    check("mul_operands_c1", {1'b0, mul_rs[7:0], mul_rd[7:0]}, {1'b0, 8'd3, 8'd5});
    check("c1_valid_busy", {15'd0, bus.res_valid, busy}, 17'b01);
    tick();
    check("c2_res_valid", 17'(bus.res_valid), 17'd0);
    tick();
    check("c3_res", {bus.res_valid, bus.res_data}, {1'b1, 16'd15});
    tick();
    check("c4_idle", {15'd0, busy, bus.op_ready}, 17'b01);

    // Accumulate sequence.
    run(2'b10, 16'd0, 16'd0, {1'b0, 16'd0});
    run(2'b01, 16'd100, 16'd200, {1'b0, 16'd20000});
    run(2'b01, 16'd300, 16'd100, {1'b0, 16'hC350});
    run(2'b01, 16'd200, 16'd100, {1'b1, sat_exp});
    run(2'b11, 16'd0, 16'd0, {1'b1, sat_exp});
    run(2'b00, 16'd2, 16'd3, {1'b1, 16'd6});
    run(2'b10, 16'd0, 16'd0, {1'b0, 16'd0});
    check("ovf_cleared", 17'(acc_ovf), 17'd0);

    // Truncation and accumulator isolation.
    run(2'b01, 16'h00FF, 16'h0001, {1'b0, 16'h00FF});
    run(2'b00, 16'h1234, 16'h0100, {1'b0, 16'h3400});
    run(2'b11, 16'hAAAA, 16'h5555, {1'b0, 16'h00FF});
    check("rdacc_keeps_operands", {1'b0, mul_rs}, {1'b0, 16'h1234});

    // Backpressure: result held for 5 cycles while extra requests are offered.
    bus.res_ready = 1'b0;
    issue(2'b00, 16'd7, 16'd9, 1'b1, {1'b0, 16'd63});
    begin
      int t = 0;
      while (!bus.res_valid && t < 50) begin
        tick();
        t++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      bus.op_valid = 1'b1;
      bus.op_code  = 2'b00;
      bus.op_rs    = 16'd11;
      bus.op_rd    = 16'd13;
      #1;
      check("bp_hold", {bus.res_valid, bus.res_data}, {1'b1, 16'd63});
      check("bp_op_ready", 17'(bus.op_ready), 17'd0);
      tick();
    end
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    check("bp_release", {15'd0, bus.res_valid, busy}, 17'd0);
    check("bp_no_extra", {1'b0, mul_rs}, {1'b0, 16'd7});

    // Reset during WAIT of MAC 10*10 with acc=5.
    run(2'b10, 16'd0, 16'd0, {1'b0, 16'd0});
    run(2'b01, 16'd5, 16'd1, {1'b0, 16'd5});
    issue(2'b01, 16'd10, 16'd10, 1'b0, 17'd0);
    check("wait_state", 17'(dbg_state), 17'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_valid", 17'(bus.res_valid), 17'd0);
      tick();
    end
    run(2'b11, 16'd0, 16'd0, {1'b0, 16'd0});
    check("abort_ovf", 17'(acc_ovf), 17'd0);

    repeat (3) tick();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_results: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequential execute-stage controller that sits on both sides of the 16-bit combinational multiplier.
- Upstream: registers operands and drives them onto the multiplier inputs. Downstream: samples the 16-bit product after a fixed multicycle settle window.
- Performs MUL (product only) or MAC (accumulate product into an internal 16-bit accumulator).
- Returns results over a valid/ready handshake to CPU writeback.

Parameters:
- MUL_WAIT, 2, cycles the product is allowed to settle before sampling; legal range 1..15; 4-bit counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  request valid
- op_ready  out  1  block can accept a request
- op_code  in  2  00 MUL, 01 MAC, 10 CLR (clear accumulator), 11 RDACC (read accumulator)
- op_rs  in  16  operand A
- op_rd  in  16  operand B
- mul_rs  out  16  registered operand A to multiplier
- mul_rd  out  16  registered operand B to multiplier
- mul_q  in  16  product from multiplier (low 16 bits)
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_data  out  16  result
- acc_ovf  out  1  sticky accumulator overflow flag
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; acc, acc_ovf, mul_rs, mul_rd, res_data all 0; res_valid 0; busy 0.
- op_ready is (state==IDLE) && !rst, so it is low in the reset cycle and high the cycle after.
- FSM states: IDLE, WAIT, RESP.
- IDLE, on op_valid && op_ready (call this cycle 0): latch op_code.
  - MUL/MAC: mul_rs<=op_rs, mul_rd<=op_rd, counter<=MUL_WAIT-1, go to WAIT.
  - CLR: acc<=0, acc_ovf<=0, res_data<=0, go to RESP.
  - RDACC: res_data<=acc, go to RESP; mul_rs and mul_rd unchanged.
- WAIT: occupies cycles 1..MUL_WAIT. The counter decrements each cycle. In the cycle the counter==0, mul_q is sampled:
  - MUL: res_data<=mul_q; acc untouched.
  - MAC: sum = {1'b0,acc} + {1'b0,mul_q} (17-bit); acc<=sum[15:0]; res_data<=sum[15:0]; acc_ovf<=acc_ovf | sum[16].
  - Then go to RESP.
- Latency: MUL/MAC res_valid rises in cycle MUL_WAIT+1. CLR/RDACC res_valid rises in cycle 1.
- RESP: res_valid=1. res_data is held stable until res_valid && res_ready, then the next state is IDLE.
  - No overlap: op_ready is 0 in WAIT and RESP, and op_valid is ignored there.
  - Minimum back-to-back spacing is one IDLE cycle between results.
- mul_rs and mul_rd change only on acceptance of MUL/MAC and are stable throughout WAIT.
- Product width: low 16 bits only, with silent truncation. MUL never sets acc_ovf.
- Reset mid-operation (WAIT or RESP): abort immediately. No acc update occurs and no res_valid pulse is produced; all registers take reset values.
- Reset and op_valid in the same cycle: reset wins and the request is dropped.
- acc_ovf is cleared only by CLR or rst.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: on a MAC with sum[16]==1, acc and res_data are set to 16'hFFFF (unsigned saturation), and acc_ovf is set.
- Undefined: wrap-around to sum[15:0], and acc_ovf is set.
- MUL, CLR and RDACC are identical in both builds.

Test Plan:
- Reset: assert rst for 2 cycles -> all outputs 0, op_ready 0 during rst and 1 on the first cycle after.
- MUL 3*5, MUL_WAIT=2, res_ready=1 -> mul_rs=3 and mul_rd=5 from cycle 1; res_valid=1 with res_data=15 in cycle 3; back in IDLE in cycle 4.
- Accumulate sequence:
  - CLR -> res_data 0.
  - MAC 100*200 -> 20000.
  - MAC 300*100 -> 50000 (0xC350), acc_ovf 0.
  - MAC 200*100 -> 0x1170 with acc_ovf=1; with MAC_SAT_EN, 0xFFFF with acc_ovf=1.
  - Following CLR -> acc_ovf 0.
- Truncation and isolation: after acc=0x00FF, MUL 0x1234*0x0100 -> res_data 0x3400; RDACC -> 0x00FF.
- Backpressure: hold res_ready=0 for 5 cycles in RESP while pulsing op_valid -> res_valid and res_data held, op_ready 0, no extra request accepted; completes on the cycle res_ready=1.
- Reset in WAIT during MAC 10*10 with acc=5 -> no res_valid; a subsequent RDACC returns 0 and acc_ovf is 0.
